// File: rtl/fifo_wconv_pkg.sv
// rtl/fifo_wconv_pkg.sv - width-ratio helpers shared by the width-converting FIFO
package fifo_wconv_pkg;

   localparam int MAX_WIDTH_RATIO = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int unit_width(input int w, input int r);
      return (w < r) ? w : r;
   endfunction

   function automatic bit ratio_legal(input int w, input int r);
      int lo;
      int hi;
      int q;
      lo = unit_width(w, r);
      hi = (w < r) ? r : w;
      if (lo < 1 || (hi % lo) != 0) return 1'b0;
      q = hi / lo;
      return (q <= MAX_WIDTH_RATIO) && ((q & (q - 1)) == 0);
   endfunction

endpackage

// File: rtl/fifo_sync_wconv_if.sv
// rtl/fifo_sync_wconv_if.sv - write/read handshake bundle of the width-converting FIFO
interface fifo_sync_wconv_if #(
   parameter int WRITE_DATA_WIDTH = 32,
   parameter int READ_DATA_WIDTH  = 32,
   parameter int WR_CNT_W         = 8,
   parameter int RD_CNT_W         = 8
);
   logic                        wr_en;
   logic [WRITE_DATA_WIDTH-1:0] din;
   logic                        full;
   logic                        overflow;
   logic                        wr_rst_busy;
   logic                        rd_en;
   logic [READ_DATA_WIDTH-1:0]  dout;
   logic                        empty;
   logic                        underflow;
   logic                        rd_rst_busy;
   logic                        prog_full;
   logic                        prog_empty;
   logic [WR_CNT_W-1:0]         wr_data_count;
   logic [RD_CNT_W-1:0]         rd_data_count;

   modport master (
      output wr_en, din, rd_en,
      input  full, overflow, wr_rst_busy, dout, empty, underflow, rd_rst_busy,
             prog_full, prog_empty, wr_data_count, rd_data_count
   );

   modport slave (
      input  wr_en, din, rd_en,
      output full, overflow, wr_rst_busy, dout, empty, underflow, rd_rst_busy,
             prog_full, prog_empty, wr_data_count, rd_data_count
   );
endinterface

// File: rtl/fifo_wconv_ram.sv
// rtl/fifo_wconv_ram.sv - dual-port RAM of min-width units, packs/unpacks words per access
// Unit at the lowest address maps to the MSB chunk of the word on both ports.
module fifo_wconv_ram
   import fifo_wconv_pkg::*;
#(
   parameter int UNIT_W      = 32,
   parameter int WR_UNITS    = 1,
   parameter int RD_UNITS    = 1,
   parameter int DEPTH_UNITS = 128,
   parameter logic [RD_UNITS*UNIT_W-1:0] RST_VAL = '0,
   localparam int AW = clog2(DEPTH_UNITS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we_i,
   input  logic [AW-1:0]              waddr_i,
   input  logic [WR_UNITS*UNIT_W-1:0] wdata_i,
   input  logic                       re_i,
   input  logic [AW-1:0]              raddr_i,
   output logic [RD_UNITS*UNIT_W-1:0] rdata_o
);
   logic [UNIT_W-1:0]          mem_q [DEPTH_UNITS];
   logic [RD_UNITS*UNIT_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int i = 0; i < WR_UNITS; i++) begin
            mem_q[waddr_i + AW'(i)] <= wdata_i[(WR_UNITS-i)*UNIT_W-1 -: UNIT_W];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q <= RST_VAL;
      end else if (re_i) begin
         for (int i = 0; i < RD_UNITS; i++) begin
            rdata_q[(RD_UNITS-i)*UNIT_W-1 -: UNIT_W] <= mem_q[raddr_i + AW'(i)];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_sync_wconv.sv
// rtl/fifo_sync_wconv.sv - single-clock FIFO with asymmetric write/read widths, read latency 1
// Define FIFO_PROG_FLAGS_EN to enable the prog_full/prog_empty threshold flags.
module fifo_sync_wconv
   import fifo_wconv_pkg::*;
#(
   parameter int FIFO_WRITE_DEPTH  = 128,
   parameter int WRITE_DATA_WIDTH  = 32,
   parameter int READ_DATA_WIDTH   = 32,
   parameter int PROG_FULL_THRESH  = 10,
   parameter int PROG_EMPTY_THRESH = 10,
   parameter bit FULL_RESET_VALUE  = 1'b0,
   parameter logic [READ_DATA_WIDTH-1:0] DOUT_RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   fifo_sync_wconv_if.slave bus
);
   localparam int UW    = unit_width(WRITE_DATA_WIDTH, READ_DATA_WIDTH);
   localparam int WU    = WRITE_DATA_WIDTH / UW;
   localparam int RU    = READ_DATA_WIDTH / UW;
   localparam int UNITS = FIFO_WRITE_DEPTH * WU;
   localparam int AW    = clog2(UNITS);
   localparam int CW    = AW + 1;
   localparam int WCW   = clog2(FIFO_WRITE_DEPTH) + 1;
   localparam int RCW   = clog2(UNITS / RU) + 1;

   if (!ratio_legal(WRITE_DATA_WIDTH, READ_DATA_WIDTH)) begin : g_bad_ratio
      $error("fifo_sync_wconv: width ratio must be 1, 2, 4 or 8");
   end
   if (FIFO_WRITE_DEPTH < 16 || FIFO_WRITE_DEPTH > 4096 ||
       (1 << clog2(FIFO_WRITE_DEPTH)) != FIFO_WRITE_DEPTH) begin : g_bad_depth
      $error("fifo_sync_wconv: FIFO_WRITE_DEPTH must be a power of 2 in 16..4096");
   end
   if (PROG_FULL_THRESH < 0 || PROG_EMPTY_THRESH < 0) begin : g_bad_thresh
      $error("fifo_sync_wconv: programmable thresholds must be non-negative");
   end

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [AW-1:0]  wptr_q, rptr_q;
   logic [1:0]     busy_q;
   logic           overflow_q, underflow_q;
   logic           busy, full_true, empty_true, wr_ok, rd_ok;
   logic [WCW-1:0] wr_cnt;
   logic [RCW-1:0] rd_cnt;

   assign busy       = busy_q[1];
   assign full_true  = (CW'(UNITS) - cnt_q) < CW'(WU);
   assign empty_true = cnt_q < CW'(RU);
   assign wr_ok      = bus.wr_en && !full_true && !busy;
   assign rd_ok      = bus.rd_en && !empty_true && !busy;

   always_comb begin
      cnt_d = cnt_q;
      if (wr_ok) cnt_d = cnt_d + CW'(WU);
      if (rd_ok) cnt_d = cnt_d - CW'(RU);
   end

   // busy_q shifts out the reset ones so both busy flags hold for two edges after release
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q       <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         busy_q      <= 2'b11;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         busy_q      <= {busy_q[0], 1'b0};
         cnt_q       <= cnt_d;
         overflow_q  <= bus.wr_en && full_true && !busy;
         underflow_q <= bus.rd_en && empty_true && !busy;
         if (wr_ok) wptr_q <= wptr_q + AW'(WU);
         if (rd_ok) rptr_q <= rptr_q + AW'(RU);
      end
   end

   fifo_wconv_ram #(
      .UNIT_W      (UW),
      .WR_UNITS    (WU),
      .RD_UNITS    (RU),
      .DEPTH_UNITS (UNITS),
      .RST_VAL     (DOUT_RESET_VALUE)
   ) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we_i    (wr_ok),
      .waddr_i (wptr_q),
      .wdata_i (bus.din),
      .re_i    (rd_ok),
      .raddr_i (rptr_q),
      .rdata_o (bus.dout)
   );

   assign wr_cnt            = WCW'(cnt_q >> clog2(WU));
   assign rd_cnt            = RCW'(cnt_q >> clog2(RU));
   assign bus.wr_data_count = wr_cnt;
   assign bus.rd_data_count = rd_cnt;
   assign bus.full          = busy ? FULL_RESET_VALUE : full_true;
   assign bus.empty         = empty_true;
   assign bus.overflow      = overflow_q;
   assign bus.underflow     = underflow_q;
   assign bus.wr_rst_busy   = busy;
   assign bus.rd_rst_busy   = busy;

`ifdef FIFO_PROG_FLAGS_EN
   assign bus.prog_full  = int'(wr_cnt) >= PROG_FULL_THRESH;
   assign bus.prog_empty = int'(rd_cnt) <= PROG_EMPTY_THRESH;
`else
   assign bus.prog_full  = 1'b0;
   assign bus.prog_empty = 1'b1;
`endif
endmodule

// File: tb/tb_fifo_sync_wconv.sv
// tb/tb_fifo_sync_wconv.sv - self-checking bench for fifo_sync_wconv
module tb_fifo_sync_wconv;
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

`ifdef FIFO_PROG_FLAGS_EN
   localparam bit PROG_EN = 1'b1;
`else
   localparam bit PROG_EN = 1'b0;
`endif

   fifo_sync_wconv_if #(.WRITE_DATA_WIDTH(128), .READ_DATA_WIDTH(32), .WR_CNT_W(5), .RD_CNT_W(7)) bus_a ();
   fifo_sync_wconv_if #(.WRITE_DATA_WIDTH(32), .READ_DATA_WIDTH(128), .WR_CNT_W(5), .RD_CNT_W(3)) bus_b ();
   fifo_sync_wconv_if #(.WRITE_DATA_WIDTH(32), .READ_DATA_WIDTH(32), .WR_CNT_W(5), .RD_CNT_W(5)) bus_c ();

   fifo_sync_wconv #(.FIFO_WRITE_DEPTH(16), .WRITE_DATA_WIDTH(128), .READ_DATA_WIDTH(32))
      dut_a (.clk(clk), .reset(reset), .bus(bus_a));
   fifo_sync_wconv #(.FIFO_WRITE_DEPTH(16), .WRITE_DATA_WIDTH(32), .READ_DATA_WIDTH(128))
      dut_b (.clk(clk), .reset(reset), .bus(bus_b));
   fifo_sync_wconv #(.FIFO_WRITE_DEPTH(16), .WRITE_DATA_WIDTH(32), .READ_DATA_WIDTH(32))
      dut_c (.clk(clk), .reset(reset), .bus(bus_c));

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] din;
      int          cnt;
      logic [31:0] dout;
      logic        ovf;
      logic        udf;
   } vec_t;
   vec_t tbl [8];

   logic [31:0]  cq [$];
   logic [127:0] sq [$];
   logic [31:0]  c_dout, r_d;
   logic         r_wr, r_rd, e_ovf, e_udf;
   logic         a_wr, a_rd, b_wr, b_rd, a_vld, flag_err;
   logic [31:0]  a_exp [4];
   int           sent, got;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_pf(input int words);
      return PROG_EN ? (words >= 10) : 1'b0;
   endfunction

   function automatic logic exp_pe(input int words);
      return PROG_EN ? (words <= 10) : 1'b1;
   endfunction

   function automatic logic [127:0] mkword(input int n);
      logic [31:0] v;
      v = 32'(n);
      return {v, ~v, v * 32'd3, v ^ 32'h5A5A_5A5A};
   endfunction

   // Compare the 32/32 FIFO against a word count and expected read data
   task automatic chk_c(input string tag, input int cnt, input logic [31:0] dout,
                        input logic ovf, input logic udf);
      chk({tag, "_wrcnt"}, 128'(bus_c.wr_data_count), 128'(cnt));
      chk({tag, "_rdcnt"}, 128'(bus_c.rd_data_count), 128'(cnt));
      chk({tag, "_full"}, 128'(bus_c.full), 128'(cnt == 16));
      chk({tag, "_empty"}, 128'(bus_c.empty), 128'(cnt == 0));
      chk({tag, "_ovf"}, 128'(bus_c.overflow), 128'(ovf));
      chk({tag, "_udf"}, 128'(bus_c.underflow), 128'(udf));
      chk({tag, "_dout"}, 128'(bus_c.dout), 128'(dout));
      chk({tag, "_pfull"}, 128'(bus_c.prog_full), 128'(exp_pf(cnt)));
      chk({tag, "_pempty"}, 128'(bus_c.prog_empty), 128'(exp_pe(cnt)));
   endtask

   task automatic idle_all();
      bus_a.wr_en = 1'b0; bus_a.rd_en = 1'b0; bus_a.din = '0;
      bus_b.wr_en = 1'b0; bus_b.rd_en = 1'b0; bus_b.din = '0;
      bus_c.wr_en = 1'b0; bus_c.rd_en = 1'b0; bus_c.din = '0;
   endtask

   initial begin
      tbl[0] = '{1'b0, 1'b1, 32'h0,  0, 32'h0,  1'b0, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 32'h11, 1, 32'h0,  1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 32'h22, 2, 32'h0,  1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b1, 32'h33, 2, 32'h11, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 32'h0,  1, 32'h22, 1'b0, 1'b0};
      tbl[5] = '{1'b0, 1'b1, 32'h0,  0, 32'h33, 1'b0, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 32'h0,  0, 32'h33, 1'b0, 1'b1};
      tbl[7] = '{1'b0, 1'b0, 32'h0,  0, 32'h33, 1'b0, 1'b0};
      a_exp[0] = 32'h4; a_exp[1] = 32'h3; a_exp[2] = 32'h2; a_exp[3] = 32'h1;

      // reset held 5 cycles with a write request pending
      idle_all();
      bus_c.wr_en = 1'b1;
      bus_c.din   = 32'hFFFF_0000;
      repeat (5) tick();
      chk("rst_empty_a", 128'(bus_a.empty), 128'(1));
      chk("rst_empty_c", 128'(bus_c.empty), 128'(1));
      chk("rst_full_c", 128'(bus_c.full), 128'(0));
      chk("rst_wbusy_c", 128'(bus_c.wr_rst_busy), 128'(1));
      chk("rst_rbusy_c", 128'(bus_c.rd_rst_busy), 128'(1));
      chk("rst_dout_a", 128'(bus_a.dout), 128'(0));
      chk("rst_ovf_c", 128'(bus_c.overflow), 128'(0));
      chk("rst_pempty_c", 128'(bus_c.prog_empty), 128'(1));
      reset = 1'b0;
      tick();
      chk("busy1_c", 128'(bus_c.wr_rst_busy), 128'(1));
      chk("busy1_cnt_c", 128'(bus_c.wr_data_count), 128'(0));
      tick();
      bus_c.wr_en = 1'b0;
      chk("busy2_c", 128'(bus_c.wr_rst_busy), 128'(0));
      chk("busy2_rd_c", 128'(bus_c.rd_rst_busy), 128'(0));
      chk("busy2_cnt_c", 128'(bus_c.wr_data_count), 128'(0));
      chk("busy2_full_c", 128'(bus_c.full), 128'(0));
      chk("busy2_empty_c", 128'(bus_c.empty), 128'(1));

      // table-driven vectors on the 32/32 FIFO
      for (int i = 0; i < 8; i++) begin
         bus_c.wr_en = tbl[i].wr;
         bus_c.rd_en = tbl[i].rd;
         bus_c.din   = tbl[i].din;
         tick();
         chk_c($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].ovf, tbl[i].udf);
      end

      // fill to full, overflow, read+write on full
      bus_c.rd_en = 1'b0;
      bus_c.wr_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         bus_c.din = 32'h100 + 32'(i);
         tick();
         if (i == 14) chk_c("fill15", 15, 32'h33, 1'b0, 1'b0);
      end
      chk_c("fill16", 16, 32'h33, 1'b0, 1'b0);
      bus_c.din = 32'hDEAD;
      tick();
      chk_c("ovf", 16, 32'h33, 1'b1, 1'b0);
      bus_c.wr_en = 1'b0;
      tick();
      chk_c("ovf_clr", 16, 32'h33, 1'b0, 1'b0);
      bus_c.wr_en = 1'b1;
      bus_c.rd_en = 1'b1;
      bus_c.din   = 32'hBEEF;
      tick();
      chk_c("rdwr_full", 15, 32'h100, 1'b1, 1'b0);
      bus_c.din = 32'hCAFE;
      tick();
      chk_c("rdwr", 15, 32'h101, 1'b0, 1'b0);
      idle_all();

      // asynchronous reset with data stored
      reset = 1'b1;
      #2;
      chk("arst_cnt", 128'(bus_c.wr_data_count), 128'(0));
      chk("arst_empty", 128'(bus_c.empty), 128'(1));
      chk("arst_busy", 128'(bus_c.wr_rst_busy), 128'(1));
      chk("arst_dout", 128'(bus_c.dout), 128'(0));
      tick();
      tick();
      reset = 1'b0;
      tick();
      tick();
      chk_c("post_rst", 0, 32'h0, 1'b0, 1'b0);

      // randomized traffic against a queue model
      c_dout = 32'h0;
      for (int i = 0; i < 400; i++) begin
         r_wr  = ($urandom_range(0, 9) < ((i < 200) ? 7 : 3));
         r_rd  = ($urandom_range(0, 9) < ((i < 200) ? 3 : 7));
         r_d   = $urandom;
         e_ovf = r_wr && (cq.size() == 16);
         e_udf = r_rd && (cq.size() == 0);
         if (r_rd && cq.size() > 0) c_dout = cq.pop_front();
         if (r_wr && !e_ovf) cq.push_back(r_d);
         bus_c.wr_en = r_wr;
         bus_c.rd_en = r_rd;
         bus_c.din   = r_d;
         tick();
         chk_c($sformatf("rnd%0d", i), cq.size(), c_dout, e_ovf, e_udf);
      end
      idle_all();

      // 128 -> 32: one wide word read back MSB chunk first
      bus_a.wr_en = 1'b1;
      bus_a.din   = 128'h00000004_00000003_00000002_00000001;
      tick();
      bus_a.wr_en = 1'b0;
      chk("a_rdcnt", 128'(bus_a.rd_data_count), 128'(4));
      chk("a_wrcnt", 128'(bus_a.wr_data_count), 128'(1));
      chk("a_empty0", 128'(bus_a.empty), 128'(0));
      bus_a.rd_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("a_dout%0d", k), 128'(bus_a.dout), 128'(a_exp[k]));
      end
      bus_a.rd_en = 1'b0;
      chk("a_empty1", 128'(bus_a.empty), 128'(1));
      chk("a_rdcnt0", 128'(bus_a.rd_data_count), 128'(0));

      // 32 -> 128: partial word stays invisible, first beat lands in MSBs
      bus_b.wr_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         bus_b.din = 32'hA + 32'(k);
         tick();
         chk($sformatf("b_empty%0d", k), 128'(bus_b.empty), 128'(1));
      end
      chk("b_wrcnt3", 128'(bus_b.wr_data_count), 128'(3));
      bus_b.din = 32'hD;
      tick();
      bus_b.wr_en = 1'b0;
      chk("b_empty3", 128'(bus_b.empty), 128'(0));
      chk("b_rdcnt", 128'(bus_b.rd_data_count), 128'(1));
      bus_b.rd_en = 1'b1;
      tick();
      bus_b.rd_en = 1'b0;
      chk("b_dout", bus_b.dout, 128'h0000000A_0000000B_0000000C_0000000D);
      chk("b_empty4", 128'(bus_b.empty), 128'(1));

      // stream 2000 words through 128->32 into 32->128
      sent = 0; got = 0; a_vld = 1'b0; flag_err = 1'b0;
      for (int cyc = 0; cyc < 40000 && got < 2000; cyc++) begin
         b_wr = a_vld;
         bus_b.wr_en = b_wr;
         bus_b.din   = bus_a.dout;
         a_wr = (sent < 2000) && !bus_a.full && ($urandom_range(0, 3) != 0);
         bus_a.wr_en = a_wr;
         bus_a.din   = mkword(sent);
         if (a_wr) begin
            sq.push_back(mkword(sent));
            sent++;
         end
         a_rd = !bus_a.empty && (int'(bus_b.wr_data_count) + int'(b_wr) < 16);
         bus_a.rd_en = a_rd;
         b_rd = !bus_b.empty && ($urandom_range(0, 1) == 1);
         bus_b.rd_en = b_rd;
         tick();
         a_vld = a_rd;
         if (b_rd) begin
            if (sq.size() == 0) chk("stream_extra", bus_b.dout, 128'hX);
            else chk($sformatf("stream%0d", got), bus_b.dout, sq.pop_front());
            got++;
         end
         if (bus_a.overflow || bus_a.underflow || bus_b.overflow || bus_b.underflow)
            flag_err = 1'b1;
      end
      idle_all();
      chk("stream_count", 128'(got), 128'(2000));
      chk("stream_flags", 128'(flag_err), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
